// File: rtl/pe_feeder_pkg.sv
// Shared types and helpers for the PE-array edge feeder.
// Lanes carry operands of 2*B bits; the helper keeps that relation in one place.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int unsigned DEF_B  = 4;
  localparam int unsigned LANE_W = 2 * DEF_B;

  function automatic int unsigned lane_w(input int unsigned b);
    return 2 * b;
  endfunction

endpackage

// File: rtl/pe_skew_lane.sv
// One skewed lane: a DEPTH-stage shift register carrying data, weight and valid.
// The pipe advances every cycle and is cleared asynchronously by reset_i.
module pe_skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] weight_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] weight_o
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data   [DEPTH];
  logic [WIDTH-1:0] r_weight [DEPTH];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]   <= '0;
        r_weight[i] <= '0;
      end
    end else begin
      r_valid[0]  <= valid_i;
      r_data[0]   <= data_i;
      r_weight[0] <= weight_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_data[i]   <= r_data[i-1];
        r_weight[i] <= r_weight[i-1];
      end
    end
  end

  assign valid_o  = r_valid[DEPTH-1];
  assign data_o   = r_data[DEPTH-1];
  assign weight_o = r_weight[DEPTH-1];

endmodule

// File: rtl/pe_feeder.sv
// Streams a tile of operand vectors into the PE array edge with lane k delayed k cycles,
// zero-filling bubbles and flushing the skew pipe with zeros before signalling done.
//   state  | meaning
//   IDLE   | waiting for start_i; len_i==0 just pulses done_o
//   STREAM | ready_o high, accepting vectors until len are taken
//   DRAIN  | N zero cycles so the last vector clears the deepest lane
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int B              = 4,
  parameter int quantized_size = 8,
  parameter int LEN_W          = 8,
  localparam int LANE_W        = lane_w(B)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      data_v_i,
  input  logic [LANE_W-1:0]         data_i    [quantized_size],
  input  logic [LANE_W-1:0]         weights_i [quantized_size],
  output logic                      ready_o,
  output logic [quantized_size-1:0] valid_o,
  output logic [LANE_W-1:0]         data_o    [quantized_size],
  output logic [LANE_W-1:0]         weights_o [quantized_size],
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int DRN_W = $clog2(quantized_size + 1);

  state_e           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DRN_W-1:0] r_drn, w_drn_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;

  assign w_accept  = (r_state == STREAM) && data_v_i;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_drn   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drn   <= w_drn_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_drn_nxt   = r_drn;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = STREAM;
            w_len_nxt   = len_i;
            w_cnt_nxt   = '0;
          end
        end
      end
      STREAM: begin
        if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = DRAIN;
            w_drn_nxt   = '0;
          end
        end
      end
      DRAIN: begin
        // Last drain cycle: the final vector now sits on the deepest lane's output.
        if (r_drn == DRN_W'(quantized_size - 1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_drn_nxt = r_drn + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ready_o = (r_state == STREAM);
  assign busy_o  = (r_state != IDLE);
  assign done_o  = r_done;

  for (genvar k = 0; k < quantized_size; k++) begin : g_lane
    logic [LANE_W-1:0] w_d;
    logic [LANE_W-1:0] w_w;

    assign w_d = w_accept ? data_i[k]    : '0;
    assign w_w = w_accept ? weights_i[k] : '0;

    pe_skew_lane #(
      .DEPTH(k + 1),
      .WIDTH(LANE_W)
    ) u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (w_accept),
      .data_i  (w_d),
      .weight_i(w_w),
      .valid_o (valid_o[k]),
      .data_o  (data_o[k]),
      .weight_o(weights_o[k])
    );
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: a tile-level model predicts per-lane outputs,
// ready/busy and done timing; a negedge monitor pops and compares.
module tb_pe_feeder;
  localparam int N  = 8;
  localparam int B  = 4;
  localparam int LW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic          data_v_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic [7:0]    data_i    [N];
  logic [7:0]    weights_i [N];
  logic [7:0]    data_o    [N];
  logic [7:0]    weights_o [N];
  logic          ready_o, busy_o, done_o;
  logic [N-1:0]  valid_o;

  pe_feeder #(.B(B), .quantized_size(N), .LEN_W(LW)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .data_v_i (data_v_i),
    .data_i   (data_i),
    .weights_i(weights_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .weights_o(weights_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int cyc; logic [7:0] d; logic [7:0] w;} lane_t;
  typedef struct {int cyc; bit rdy; bit busy;} stat_t;

  lane_t lq [N][$];
  stat_t sq [$];
  int    dq [$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  // Tile model: vectors still owed, and the first interval at which the feeder is idle again.
  int m_rem = 0;
  int m_idle_from = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic model_reset();
    m_rem = 0;
    m_idle_from = 0;
    sq.delete();
    dq.delete();
    for (int k = 0; k < N; k++) lq[k].delete();
  endtask

  // Present inputs for the coming edge, predict its effect, then wait to the next negedge.
  task automatic cycle(input bit st, input logic [7:0] len, input bit dv, input bit pat);
    int  e;
    bit  idle_now;
    stat_t s;
    lane_t l;
    start_i  = st;
    len_i    = len;
    data_v_i = dv;
    for (int k = 0; k < N; k++) begin
      data_i[k]    = pat ? 8'(8'h10 + k) : 8'($urandom);
      weights_i[k] = 8'($urandom);
    end
    e = cyc + 1;
    idle_now = (m_rem == 0) && (cyc >= m_idle_from);
    if (idle_now && st) begin
      if (len == 8'd0) dq.push_back(e);
      else m_rem = int'(len);
    end else if (m_rem > 0 && dv) begin
      for (int k = 0; k < N; k++) begin
        l.cyc = e + k;
        l.d   = data_i[k];
        l.w   = weights_i[k];
        lq[k].push_back(l);
      end
      m_rem--;
      if (m_rem == 0) begin
        m_idle_from = e + N;
        dq.push_back(e + N);
      end
    end
    s.cyc  = e;
    s.rdy  = (m_rem > 0);
    s.busy = !((m_rem == 0) && (e >= m_idle_from));
    sq.push_back(s);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    bit nz;
    nz = ready_o | busy_o | done_o | (|valid_o);
    for (int k = 0; k < N; k++) nz = nz | (|data_o[k]) | (|weights_o[k]);
    checks++;
    if (nz) begin
      failures++;
      $display("FAIL %s got ready=%b busy=%b done=%b valid=%h (or nonzero lane data) want all outputs 0",
               name, ready_o, busy_o, done_o, valid_o);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < N; k++) begin
        checks++;
        if (valid_o[k]) begin
          if (lq[k].size() == 0 || lq[k][0].cyc != cyc) begin
            failures++;
            $display("FAIL lane%0d_unexpected_valid cyc=%0d got d=%h w=%h want no valid", k, cyc,
                     data_o[k], weights_o[k]);
          end else begin
            if (data_o[k] !== lq[k][0].d || weights_o[k] !== lq[k][0].w) begin
              failures++;
              $display("FAIL lane%0d_data cyc=%0d got d=%h w=%h want d=%h w=%h", k, cyc,
                       data_o[k], weights_o[k], lq[k][0].d, lq[k][0].w);
            end
            void'(lq[k].pop_front());
          end
        end else if (lq[k].size() != 0 && lq[k][0].cyc == cyc) begin
          failures++;
          $display("FAIL lane%0d_missing_valid cyc=%0d got valid=0 want d=%h w=%h", k, cyc,
                   lq[k][0].d, lq[k][0].w);
          void'(lq[k].pop_front());
        end else if (data_o[k] !== 8'h00 || weights_o[k] !== 8'h00) begin
          failures++;
          $display("FAIL lane%0d_bubble_zero cyc=%0d got d=%h w=%h want 00", k, cyc,
                   data_o[k], weights_o[k]);
        end
      end
      checks++;
      if (done_o) begin
        if (dq.size() != 0 && dq[0] == cyc) void'(dq.pop_front());
        else begin
          failures++;
          $display("FAIL done_unexpected cyc=%0d got done=1 want 0", cyc);
        end
      end else if (dq.size() != 0 && dq[0] == cyc) begin
        failures++;
        $display("FAIL done_missing cyc=%0d got done=0 want 1", cyc);
        void'(dq.pop_front());
      end
      while (sq.size() != 0 && sq[0].cyc < cyc) void'(sq.pop_front());
      if (sq.size() != 0 && sq[0].cyc == cyc) begin
        checks++;
        if (ready_o !== sq[0].rdy || busy_o !== sq[0].busy) begin
          failures++;
          $display("FAIL status cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc,
                   ready_o, busy_o, sq[0].rdy, sq[0].busy);
        end
        void'(sq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    for (int k = 0; k < N; k++) begin
      data_i[k] = '0;
      weights_i[k] = '0;
    end
    // Reset held with random inputs
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      start_i  = 1'($urandom);
      data_v_i = 1'($urandom);
      len_i    = 8'($urandom);
      for (int k = 0; k < N; k++) begin
        data_i[k] = 8'($urandom);
        weights_i[k] = 8'($urandom);
      end
      #1 check_zero("reset_hold");
    end
    start_i = 1'b0;
    data_v_i = 1'b0;
    #2 reset_i = 1'b1;
    @(negedge clk_i);
    check_zero("after_release");
    idle(2);

    // Three-vector tile with a fixed lane pattern
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 1'b1, 1'b1);
    idle(12);

    // Four vectors with a bubble after the second
    cycle(1'b1, 8'd4, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    idle(12);

    // Zero-length tile
    cycle(1'b1, 8'd0, 1'b0, 1'b0);
    idle(4);

    // Back-to-back: start ignored mid-stream, new start in the done cycle
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    cycle(1'b1, 8'd7, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    idle(N);
    cycle(1'b1, 8'd2, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    idle(12);

    // Randomized tiles, bubbles and stray starts
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 7) == 0, 8'($urandom_range(0, 6)), $urandom_range(0, 3) != 0, 1'b0);
    idle(12);

    // Asynchronous reset two vectors into a five-vector tile
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    #2 reset_i = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    start_i = 1'b0;
    data_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 reset_i = 1'b1;
    @(negedge clk_i);
    idle(12);
    cycle(1'b1, 8'd2, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    idle(12);

    left = dq.size();
    for (int k = 0; k < N; k++) left += lq[k].size();
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL leftover_expectations got %0d pending want 0", left);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
